// File: rtl/sevenseg_scan_ctrl_if.sv
// Load-side interface of the seven-segment scan controller.
// The source (master) presents hex nibbles and decimal points with a valid flag.
// The controller (slave) answers with ready while its pending buffer is empty.
interface sevenseg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] DATA_IN;
    logic [NUM_DIGITS-1:0]   DP_IN;
    logic                    DATA_VALID;
    logic                    DATA_READY;

    modport master (
        output DATA_IN,
        output DP_IN,
        output DATA_VALID,
        input  DATA_READY
    );

    modport slave (
        input  DATA_IN,
        input  DP_IN,
        input  DATA_VALID,
        output DATA_READY
    );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// - Walks an active-low one-hot anode select across NUM_DIGITS digits, one slot of
//   TICK_DIV cycles each, and blanks the first BLANK_CYCLES of every slot so the
//   previous digit's segments cannot ghost onto the next anode.
// - Display data is double-buffered: a load fills the pending buffer and only
//   moves into the display register at a frame boundary, so a frame never mixes
//   old and new digits.
// - All display outputs are registered, one cycle behind the (cnt, idx) state.
// Optional feature macro: SEVENSEG_DIM_EN adds a BRIGHTNESS[3:0] input that gates
// whole frames out of every 16 (frame_cnt < brightness lights the frame).
module sevenseg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int TICK_DIV     = 100000,
    parameter int BLANK_CYCLES = 2000
) (
    input  logic                   CLK100MHZ,
    input  logic                   CPU_RESETN,
    sevenseg_scan_ctrl_if.slave    load_if,
`ifdef SEVENSEG_DIM_EN
    input  logic [3:0]             BRIGHTNESS,
`endif
    output logic [NUM_DIGITS-1:0]  AN,
    output logic [6:0]             SEG,
    output logic                   DP
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        PH_BLANK,
        PH_DRIVE
    } phase_e;

    // Active-low gfedcba pattern for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Scan position
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    wrap;
    logic                    frame_end;

    // Double buffer and handshake
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pend_full_q, pend_full_d;
    logic                    ready_q, ready_d;
    logic                    accept;

    // Registered display outputs
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    phase_e                  phase;
    logic                    lit;

`ifdef SEVENSEG_DIM_EN
    logic [3:0]              frame_cnt_q, frame_cnt_d;
    logic [3:0]              bright_q, bright_d;
`endif

    // Slot counter and digit index: cnt wraps every TICK_DIV cycles, idx steps on the wrap.
    always_comb begin
        wrap      = (cnt_q == CNT_MAX);
        frame_end = wrap && (idx_q == IDX_MAX);
        cnt_d     = wrap ? '0 : cnt_q + 1'b1;
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        idx_d     = idx_q;
        if (wrap) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end
    end

    // Load handshake and frame-boundary swap of pending into display.
    always_comb begin
        accept      = load_if.DATA_VALID && ready_q;
        disp_d      = disp_q;
        disp_dp_d   = disp_dp_q;
        pend_d      = pend_q;
        pend_dp_d   = pend_dp_q;
        pend_full_d = pend_full_q;
        // The swap only sees data that was already pending before this edge, so a
        // load accepted on the boundary cycle itself waits for the next boundary.
        if (frame_end && pend_full_q) begin
            disp_d      = pend_q;
            disp_dp_d   = pend_dp_q;
            pend_full_d = 1'b0;
        end
        // accept implies pend_full_q == 0, so it can never collide with the swap.
        if (accept) begin
            pend_d      = load_if.DATA_IN;
            pend_dp_d   = load_if.DP_IN;
            pend_full_d = 1'b1;
        end
        ready_d = ~pend_full_d;
    end

`ifdef SEVENSEG_DIM_EN
    // Frame counter and brightness sample, both updated only at frame boundaries.
    always_comb begin
        frame_cnt_d = frame_end ? frame_cnt_q + 4'd1 : frame_cnt_q;
        bright_d    = frame_end ? BRIGHTNESS : bright_q;
    end
`endif

    // Phase decode and next display outputs from the current (cnt, idx).
    always_comb begin
        phase = (32'(cnt_q) < 32'(BLANK_CYCLES)) ? PH_BLANK : PH_DRIVE;
`ifdef SEVENSEG_DIM_EN
        lit   = (phase == PH_DRIVE) && (frame_cnt_q < bright_q);
`else
        lit   = (phase == PH_DRIVE);
`endif
        an_d  = '1;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (lit) begin
            an_d[idx_q] = 1'b0;
            seg_d       = hex_to_seg(disp_q[4*int'(idx_q) +: 4]);
            dp_d        = ~disp_dp_q[idx_q];
        end
    end

    // State and output registers; reset blanks the display at once, without a clock.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        // NOTE: the buffers are a few flops, not a RAM, so resetting them costs nothing
        // and guarantees a blank "0000" after reset with any stale load discarded.
        if (!CPU_RESETN) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            disp_q      <= '0;
            disp_dp_q   <= '0;
            pend_q      <= '0;
            pend_dp_q   <= '0;
            pend_full_q <= 1'b0;
            ready_q     <= 1'b1;
            an_q        <= '1;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
`ifdef SEVENSEG_DIM_EN
            frame_cnt_q <= 4'd0;
            bright_q    <= 4'd15;
`endif
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge state.
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            disp_q      <= disp_d;
            disp_dp_q   <= disp_dp_d;
            pend_q      <= pend_d;
            pend_dp_q   <= pend_dp_d;
            pend_full_q <= pend_full_d;
            ready_q     <= ready_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
`ifdef SEVENSEG_DIM_EN
            frame_cnt_q <= frame_cnt_d;
            bright_q    <= bright_d;
`endif
        end
    end

    assign AN                 = an_q;
    assign SEG                = seg_q;
    assign DP                 = dp_q;
    assign load_if.DATA_READY = ready_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Testbench for sevenseg_scan_ctrl with NUM_DIGITS=4, TICK_DIV=8, BLANK_CYCLES=2.
// A timeline model derives every expected output from the number of clock edges
// since reset (slot position, digit, frame) plus the list of accepted loads; a
// compare process checks it each cycle, and directed checks pin literal values.
// Build with SEVENSEG_DIM_EN defined to exercise the brightness gating too.
module tb_sevenseg_scan_ctrl;

    localparam int ND    = 4;
    localparam int TICK  = 8;
    localparam int BLANK = 2;
    localparam int FRAME = TICK * ND;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [ND-1:0] an;
    logic [6:0]    seg;
    logic          dp;
`ifdef SEVENSEG_DIM_EN
    logic [3:0]    brightness = 4'd15;
`endif

    sevenseg_scan_ctrl_if #(.NUM_DIGITS(ND)) load_if ();

    sevenseg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .TICK_DIV    (TICK),
        .BLANK_CYCLES(BLANK)
    ) dut (
        .CLK100MHZ (clk),
        .CPU_RESETN(rst_n),
        .load_if   (load_if),
`ifdef SEVENSEG_DIM_EN
        .BRIGHTNESS(brightness),
`endif
        .AN        (an),
        .SEG       (seg),
        .DP        (dp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %h, expected %h", name, m_n, act, exp);
        end
    endtask

    // Hex decode table, active-low gfedcba.
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // ---------------- timeline model ----------------
    int          m_n = 0;           // rising edges since reset release
    logic [15:0] m_disp = '0;
    logic [3:0]  m_disp_dp = '0;
    logic [15:0] m_pend = '0;
    logic [3:0]  m_pend_dp = '0;
    bit          m_full = 1'b0;
    bit          m_ready = 1'b1;
    logic [3:0]  m_bright = 4'd15;
    logic [ND-1:0] exp_an = '1;
    logic [6:0]  exp_seg = 7'h7F;
    logic        exp_dp = 1'b1;
    logic        exp_rdy = 1'b1;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_n = 0; m_disp = '0; m_disp_dp = '0; m_pend = '0; m_pend_dp = '0;
                m_full = 1'b0; m_ready = 1'b1; m_bright = 4'd15;
                exp_an = '1; exp_seg = 7'h7F; exp_dp = 1'b1; exp_rdy = 1'b1;
            end else begin
                int  step, pos, dig, frm;
                bit  lit, acc;
                step = m_n;
                pos  = step % TICK;
                dig  = (step / TICK) % ND;
                frm  = step / FRAME;
                lit  = (pos >= BLANK);
`ifdef SEVENSEG_DIM_EN
                lit  = lit && ((frm % 16) < int'(m_bright));
`endif
                exp_an  = '1;
                exp_seg = 7'h7F;
                exp_dp  = 1'b1;
                if (lit) begin
                    exp_an[dig] = 1'b0;
                    exp_seg     = seg_tab[m_disp[4*dig +: 4]];
                    exp_dp      = ~m_disp_dp[dig];
                end
                acc = load_if.DATA_VALID && m_ready;
                m_n++;
                if (m_n % FRAME == 0) begin
                    if (m_full) begin
                        m_disp = m_pend; m_disp_dp = m_pend_dp; m_full = 1'b0;
                    end
`ifdef SEVENSEG_DIM_EN
                    m_bright = brightness;
`endif
                end
                if (acc) begin
                    m_pend = load_if.DATA_IN; m_pend_dp = load_if.DP_IN; m_full = 1'b1;
                end
                m_ready = !m_full;
                exp_rdy = m_ready;
            end
        end
    end

    // Per-cycle compare, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("an", 32'(an), 32'(exp_an));
                check("seg", 32'(seg), 32'(exp_seg));
                check("dp", 32'(dp), 32'(exp_dp));
                check("ready", 32'(load_if.DATA_READY), 32'(exp_rdy));
            end
        end
    end

    // Wait (bounded) until the negedge after rising edge number 'target'.
    task automatic goto(input int target);
        int guard = 0;
        while (m_n < target) begin
            @(negedge clk);
            guard++;
            if (guard > 5000) begin
                n_checks++;
                n_fail++;
                $display("FAIL timeout waiting for edge %0d, at edge %0d", target, m_n);
                break;
            end
        end
    endtask

    task automatic drive(input bit v, input logic [15:0] d, input logic [3:0] p);
        load_if.DATA_VALID = v;
        load_if.DATA_IN    = d;
        load_if.DP_IN      = p;
    endtask

    initial begin
        drive(1'b0, 16'h0, 4'h0);
        repeat (3) @(negedge clk);
        check("reset_an", 32'(an), 32'hF);
        check("reset_seg", 32'(seg), 32'h7F);
        check("reset_rdy", 32'(load_if.DATA_READY), 32'h1);
        rst_n = 1'b1;

        // Scan pattern with all-zero data.
        goto(1);  check("t1_blank_an", 32'(an), 32'hF);
        goto(3);  check("t1_d0_an", 32'(an), 32'hE); check("t1_d0_seg", 32'(seg), 32'h40);
        goto(11); check("t1_d1_an", 32'(an), 32'hD);
        goto(19); check("t1_d2_an", 32'(an), 32'hB);
        goto(27); check("t1_d3_an", 32'(an), 32'h7);
        goto(33); check("t1_wrap_blank", 32'(an), 32'hF);

        // Mid-frame load, displayed after the next boundary.
        goto(40); drive(1'b1, 16'h1A3F, 4'b0100);
        goto(41); drive(1'b0, 16'h0, 4'h0);
        check("t2_rdy_low", 32'(load_if.DATA_READY), 32'h0);
        goto(63); check("t2_rdy_still_low", 32'(load_if.DATA_READY), 32'h0);
        goto(64); check("t2_rdy_high", 32'(load_if.DATA_READY), 32'h1);
        goto(67); check("t2_d0_seg", 32'(seg), 32'h0E);
        goto(75); check("t2_d1_seg", 32'(seg), 32'h30);
        goto(83); check("t2_d2_seg", 32'(seg), 32'h08); check("t2_d2_dp", 32'(dp), 32'h0);
        goto(91); check("t2_d3_seg", 32'(seg), 32'h79); check("t2_d3_dp", 32'(dp), 32'h1);

        // Back-to-back loads: second held until ready returns.
        goto(100); drive(1'b1, 16'h0001, 4'h0);
        goto(101); drive(1'b1, 16'h2222, 4'h0);
        goto(127); check("t3_old_frame", 32'(seg), 32'h79);
        goto(129); drive(1'b0, 16'h0, 4'h0);
        check("t3_second_accepted", 32'(load_if.DATA_READY), 32'h0);
        goto(131); check("t3_0001_d0", 32'(seg), 32'h79);
        goto(147); check("t3_0001_d2", 32'(seg), 32'h40);
        goto(159); check("t3_0001_d3", 32'(seg), 32'h40);
        goto(163); check("t3_2222_d0", 32'(seg), 32'h24);

        // Acceptance on the exact frame-boundary edge.
        goto(191); drive(1'b1, 16'h5555, 4'h0);
        goto(192); drive(1'b0, 16'h0, 4'h0);
        check("t4_accepted", 32'(load_if.DATA_READY), 32'h0);
        goto(195); check("t4_old_data", 32'(seg), 32'h24);
        goto(224); check("t4_rdy_high", 32'(load_if.DATA_READY), 32'h1);
        goto(227); check("t4_new_data", 32'(seg), 32'h12);

        // Asynchronous reset at cnt=5 of digit 2 with a load still pending.
        goto(269); drive(1'b1, 16'h7777, 4'hF);
        goto(270); drive(1'b0, 16'h0, 4'h0);
        goto(277); check("t5_pre_an", 32'(an), 32'hB);
        #1 rst_n = 1'b0;
        #1;
        check("t5_async_an", 32'(an), 32'hF);
        check("t5_async_seg", 32'(seg), 32'h7F);
        check("t5_async_dp", 32'(dp), 32'h1);
        check("t5_async_rdy", 32'(load_if.DATA_READY), 32'h1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        goto(3);  check("t5_restart_an", 32'(an), 32'hE); check("t5_restart_seg", 32'(seg), 32'h40);
        goto(35); check("t5_pend_dropped", 32'(seg), 32'h40);

`ifdef SEVENSEG_DIM_EN
        begin
            int  lit_frames;
            int  dark_hits;
            bit  any;
            goto(40); brightness = 4'd4;
            lit_frames = 0;
            for (int f = 2; f < 18; f++) begin
                any = 1'b0;
                for (int k = 0; k < FRAME; k++) begin
                    goto(f * FRAME + k + 1);
                    if (an != '1) any = 1'b1;
                end
                if (any) lit_frames++;
            end
            check("t6_lit_frames", 32'(lit_frames), 32'd4);
            goto(580); brightness = 4'd0;
            dark_hits = 0;
            for (int k = 609; k <= 672; k++) begin
                goto(k);
                if (an != '1) dark_hits++;
            end
            check("t6_dark", 32'(dark_hits), 32'd0);
        end
`endif

        goto(m_n + 4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
